window_buffer_kxk: RTL and testbench
====================================

// Module: window_buffer_kxk
// PURPOSE
//  Parametrised KxK sliding-window register sitting after the (K-1)-line buffer.
//  Each accepted beat is one K-pixel column from the line buffer; the block shifts it into
//  a KxK window and flags the (COLS-K+1)*(ROWS-K+1) fully populated windows of a frame.
//  Generalises the fixed 3x3 window stage to any data width and odd K, with a valid_i strobe
//  that may gap, and with frame done/progress status.
// PARAMETERS
//  DATA_W  8  pixel width in bits
//  K       3  window size; odd, 3..7, K<=COLS, K<=ROWS
//  COLS    5  image width in pixels
//  ROWS    5  image height in pixels
// PORTS
//  clk              in   1               rising-edge clock
//  rst              in   1               synchronous reset, active-low (0 = reset)
//  valid_i          in   1               col_i carries a new column this cycle
//  col_i            in   K*DATA_W        column pixels; slice r (bits r*DATA_W +: DATA_W) = row r, r=0 top
//  window_o         out  K*K*DATA_W      window; pixel (r,c) at bits (r*K+c)*DATA_W, c=0 oldest/leftmost
//  valid_o          out  1               window_o holds a complete, in-frame window
//  done_o           out  1               one-cycle pulse after the frame's last window is presented
//  progress_done_o  out  1               level: frame complete, no new frame started yet
// BEHAVIOUR
//  Reset (rst=0 at clk edge): window_o=0, valid_o=0, done_o=0, progress_done_o=0,
//   col_cnt=0, row_cnt=0, FSM=IDLE. Reset mid-frame discards the frame; there is no partial done_o.
//  Shift: on each clk with valid_i=1, column c takes column c+1 (c=0..K-2); column K-1 takes col_i.
//   With valid_i=0, window_o, counters and valid_o hold state except as stated below.
//  Latency: 1 cycle; window_o and valid_o update on the edge that accepts the column.
//  Counters: col_cnt 0..COLS-1, row_cnt 0..ROWS-K; both increment on accepted beats only.
//   col_cnt wraps to 0 at COLS-1 and row_cnt increments; the window is not cleared at wrap.
//  valid_o: registered; set to 1 on an accepted beat where col_cnt (pre-increment) >= K-1,
//   otherwise set to 0. It is cleared in any cycle with valid_i=0, so it is high for exactly one
//   cycle per window.
//   The first K-1 beats of each row therefore give valid_o=0, which masks stale wrap columns.
//  FSM:
//   IDLE: progress_done_o holds its value. valid_i=1 -> RUN and clear progress_done_o.
//     That beat is accepted as column 0.
//   RUN : accepting beats. The beat with row_cnt=ROWS-K and col_cnt=COLS-1 is the last beat.
//     That beat goes to DONE and resets both counters to 0.
//   DONE: exactly one cycle; done_o=1, progress_done_o set to 1 on exit; -> IDLE.
//     valid_i=1 here is accepted as column 0 of the next frame and moves to RUN.
//     In that case progress_done_o stays 0 and done_o still pulses.
//  Windows per frame: (COLS-K+1)*(ROWS-K+1). Beats per frame: COLS*(ROWS-K+1).
//  Beats beyond a frame start the next frame; no overflow state exists.
//  Counter widths: $clog2(COLS) and $clog2(ROWS-K+1) bits, minimum 1 bit.
//  Compares are exact equality with COLS-1 and ROWS-K.
// CONFIGURATION
//  WINDOW_BUF_COORD_EN defined: adds outputs x_o [$clog2(COLS)] and y_o [$clog2(ROWS)].
//   They carry the centre-pixel coordinates of window_o and are valid with valid_o.
//   x_o = col_cnt_pre - (K-1)/2 and y_o = row_cnt + (K-1)/2, registered with window_o.
//   Both reset to 0.
//  Undefined: x_o/y_o and their registers are absent; all other behaviour is identical.
// TESTING
//  1 Reset: hold rst=0 3 cycles with valid_i=1 and col_i=all-ones.
//    -> window_o=0, valid_o=0, done_o=0, progress_done_o=0, FSM stays IDLE.
//  2 K=3, COLS=ROWS=5: stream 15 beats back-to-back, col_i = beat index per row slice.
//    -> valid_o on beats 3-5, 8-10 and 13-15 (9 windows).
//    -> first window holds columns 0,1,2; done_o pulses 1 cycle after beat 15.
//    -> progress_done_o=1 thereafter.
//  3 Same frame with valid_i=0 inserted every other cycle.
//    -> identical window sequence, valid_o never high two cycles in a row, done_o once.
//  4 Back-to-back frames, beat 1 of frame 2 presented in the DONE cycle.
//    -> done_o pulses, progress_done_o stays 0, frame 2 gives 9 windows.
//  5 Reset asserted after beat 7, then full frame.
//    -> no done_o for the aborted frame, new frame gives exactly 9 windows.
//  6 K=5, DATA_W=10, COLS=8, ROWS=6, COORD_EN defined.
//    -> 8 windows; first has x_o=2, y_o=2; last has x_o=5, y_o=3.

Source files
------------

// File: rtl/window_buffer_kxk_if.sv
// Column-in / window-out bundle for window_buffer_kxk.
// WINDOW_BUF_COORD_EN adds the x_o/y_o centre-coordinate signals.
interface window_buffer_kxk_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned COLS   = 5,
    parameter int unsigned ROWS   = 5
);
`ifdef WINDOW_BUF_COORD_EN
    localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1;
`endif

    logic                  valid_i;
    logic [K*DATA_W-1:0]   col_i;
    logic [K*K*DATA_W-1:0] window_o;
    logic                  valid_o;
    logic                  done_o;
    logic                  progress_done_o;
`ifdef WINDOW_BUF_COORD_EN
    logic [XW-1:0]         x_o;
    logic [YW-1:0]         y_o;
`endif

    modport slave (
        input  valid_i, col_i,
        output window_o, valid_o, done_o, progress_done_o
`ifdef WINDOW_BUF_COORD_EN
        , output x_o, y_o
`endif
    );

    modport master (
        output valid_i, col_i,
        input  window_o, valid_o, done_o, progress_done_o
`ifdef WINDOW_BUF_COORD_EN
        , input x_o, y_o
`endif
    );
endinterface

// File: rtl/window_buffer_kxk.sv
// KxK sliding window fed one K-pixel column per accepted beat, with frame done/progress status.
// Define WINDOW_BUF_COORD_EN to add registered centre-pixel coordinates x_o/y_o.
module window_buffer_kxk #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned COLS   = 5,
    parameter int unsigned ROWS   = 5
) (
    input  logic                clk,
    input  logic                rst,
    window_buffer_kxk_if.slave  bus_io
);
    localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW   = (ROWS - K + 1 > 1) ? $clog2(ROWS - K + 1) : 1;
    localparam int unsigned WinW = K * K * DATA_W;
    localparam logic [CW-1:0] ColLast     = CW'(COLS - 1);
    localparam logic [RW-1:0] RowLast     = RW'(ROWS - K);
    localparam logic [CW-1:0] ColFirstWin = CW'(K - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [WinW-1:0] window_q, window_d;
    logic [CW-1:0]   col_cnt_q;
    logic [RW-1:0]   row_cnt_q;
    logic            valid_q;
    logic            done_q;
    logic            progress_done_q;
    logic            col_wrap;
    logic            last_beat;

`ifdef WINDOW_BUF_COORD_EN
    localparam int unsigned XW   = CW;
    localparam int unsigned YW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned Half = (K - 1) / 2;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
`endif

    // Column c takes column c+1; the newest column enters at c = K-1.
    always_comb begin
        window_d = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                window_d[(r*K+c)*DATA_W +: DATA_W] = window_q[(r*K+c+1)*DATA_W +: DATA_W];
            end
            window_d[(r*K+K-1)*DATA_W +: DATA_W] = bus_io.col_i[r*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        col_wrap  = (col_cnt_q == ColLast);
        last_beat = col_wrap && (row_cnt_q == RowLast);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StIdle;
            window_q        <= '0;
            col_cnt_q       <= '0;
            row_cnt_q       <= '0;
            valid_q         <= 1'b0;
            done_q          <= 1'b0;
            progress_done_q <= 1'b0;
`ifdef WINDOW_BUF_COORD_EN
            x_q             <= '0;
            y_q             <= '0;
`endif
        end else begin
            // First K-1 beats of a row would expose stale columns from the previous row.
            valid_q <= bus_io.valid_i && (col_cnt_q >= ColFirstWin);
            done_q  <= 1'b0;
            if (bus_io.valid_i) begin
                window_q  <= window_d;
                col_cnt_q <= col_wrap ? '0 : col_cnt_q + 1'b1;
                if (col_wrap) begin
                    row_cnt_q <= (row_cnt_q == RowLast) ? '0 : row_cnt_q + 1'b1;
                end
`ifdef WINDOW_BUF_COORD_EN
                x_q <= XW'(col_cnt_q) - XW'(Half);
                y_q <= YW'(row_cnt_q) + YW'(Half);
`endif
            end
            unique case (state_q)
                StIdle: begin
                    if (bus_io.valid_i) begin
                        state_q         <= StRun;
                        progress_done_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (bus_io.valid_i && last_beat) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    // A beat here already belongs to the next frame.
                    if (bus_io.valid_i) begin
                        state_q <= StRun;
                    end else begin
                        state_q         <= StIdle;
                        progress_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.window_o        = window_q;
    assign bus_io.valid_o         = valid_q;
    assign bus_io.done_o          = done_q;
    assign bus_io.progress_done_o = progress_done_q;
`ifdef WINDOW_BUF_COORD_EN
    assign bus_io.x_o = x_q;
    assign bus_io.y_o = y_q;
`endif
endmodule

// File: tb/tb_window_buffer_kxk.sv
// Directed, table-driven bench for window_buffer_kxk (3x3 on 5x5, plus a 5x5 window on 8x6).
module tb_window_buffer_kxk;
    localparam int DW = 8, K = 3, COLS = 5, ROWS = 5;
    localparam int ColW = K * DW, WinW = K * K * DW;
    localparam int DW5 = 10, K5 = 5, COLS5 = 8, ROWS5 = 6;
    localparam int ColW5 = K5 * DW5, WinW5 = K5 * K5 * DW5;
    localparam int Beats = COLS * (ROWS - K + 1);

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    window_buffer_kxk_if #(.DATA_W(DW), .K(K), .COLS(COLS), .ROWS(ROWS)) bus ();
    window_buffer_kxk_if #(.DATA_W(DW5), .K(K5), .COLS(COLS5), .ROWS(ROWS5)) bus5 ();

    window_buffer_kxk #(.DATA_W(DW), .K(K), .COLS(COLS), .ROWS(ROWS)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    window_buffer_kxk #(.DATA_W(DW5), .K(K5), .COLS(COLS5), .ROWS(ROWS5)) u_dut5 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            vld;
        logic [ColW-1:0] col;
        logic            e_vld;
        logic            e_done;
        logic            e_pd;
        logic [WinW-1:0] e_win;
    } vec_t;

    vec_t tbl [Beats+1];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ColW-1:0] mkcol(input int n);
        logic [ColW-1:0] v;
        v = '0;
        for (int r = 0; r < K; r++) v[r*DW +: DW] = DW'((r << 4) | n);
        return v;
    endfunction

    // Window after beat n: column c holds beat n-(K-1)+c, zero before the first beat.
    function automatic logic [WinW-1:0] mkwin(input int n);
        logic [WinW-1:0] w;
        int idx;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                idx = n - (K - 1) + c;
                if (idx >= 0) w[(r*K+c)*DW +: DW] = DW'((r << 4) | idx);
            end
        end
        return w;
    endfunction

    function automatic logic [ColW5-1:0] mkcol5(input int n);
        logic [ColW5-1:0] v;
        v = '0;
        for (int r = 0; r < K5; r++) v[r*DW5 +: DW5] = DW5'(n * 8 + r);
        return v;
    endfunction

    function automatic logic [WinW5-1:0] mkwin5(input int n);
        logic [WinW5-1:0] w;
        int idx;
        w = '0;
        for (int r = 0; r < K5; r++) begin
            for (int c = 0; c < K5; c++) begin
                idx = n - (K5 - 1) + c;
                if (idx >= 0) w[(r*K5+c)*DW5 +: DW5] = DW5'(idx * 8 + r);
            end
        end
        return w;
    endfunction

    task automatic step(input logic v, input logic [ColW-1:0] c);
        bus.valid_i = v;
        bus.col_i   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i, input string tag);
        chk({tag, " valid_o"}, bus.valid_o, tbl[i].e_vld);
        chk({tag, " done_o"}, bus.done_o, tbl[i].e_done);
        chk({tag, " progress_done_o"}, bus.progress_done_o, tbl[i].e_pd);
        if (tbl[i].e_vld) chk({tag, " window_o"}, bus.window_o, tbl[i].e_win);
    endtask

    // Streams one frame from the table; optional idle gap after each beat and idle tail.
    task automatic run_frame(input string tag, input bit gap, input bit tail,
                             output int wins, output int dones);
        wins  = 0;
        dones = 0;
        for (int n = 0; n < Beats; n++) begin
            step(tbl[n].vld, tbl[n].col);
            check_vec(n, $sformatf("%s beat%0d", tag, n));
            if (bus.valid_o) wins++;
            if (bus.done_o) dones++;
            if (gap) begin
                step(1'b0, '0);
                chk($sformatf("%s gap%0d valid_o", tag, n), bus.valid_o, 1'b0);
                chk($sformatf("%s gap%0d done_o", tag, n), bus.done_o, 1'b0);
                chk($sformatf("%s gap%0d progress", tag, n), bus.progress_done_o, n == Beats - 1);
                if ((n % COLS) >= K - 1)
                    chk($sformatf("%s gap%0d window hold", tag, n), bus.window_o, mkwin(n));
            end
        end
        if (tail) begin
            step(tbl[Beats].vld, tbl[Beats].col);
            check_vec(Beats, {tag, " tail"});
            if (bus.done_o) dones++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wins, dones, wins5;

        for (int n = 0; n < Beats; n++) begin
            tbl[n].vld    = 1'b1;
            tbl[n].col    = mkcol(n);
            tbl[n].e_vld  = (n % COLS) >= K - 1;
            tbl[n].e_done = (n == Beats - 1);
            tbl[n].e_pd   = 1'b0;
            tbl[n].e_win  = mkwin(n);
        end
        tbl[Beats].vld    = 1'b0;
        tbl[Beats].col    = '0;
        tbl[Beats].e_vld  = 1'b0;
        tbl[Beats].e_done = 1'b0;
        tbl[Beats].e_pd   = 1'b1;
        tbl[Beats].e_win  = mkwin(Beats - 1);

        bus5.valid_i = 1'b0;
        bus5.col_i   = '0;

        // Reset held with valid input active.
        rst         = 1'b0;
        bus.valid_i = 1'b1;
        bus.col_i   = '1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("reset%0d window_o", i), bus.window_o, '0);
            chk($sformatf("reset%0d valid_o", i), bus.valid_o, 1'b0);
            chk($sformatf("reset%0d done_o", i), bus.done_o, 1'b0);
            chk($sformatf("reset%0d progress", i), bus.progress_done_o, 1'b0);
        end
        rst = 1'b1;
        step(1'b0, '0);
        chk("post-reset valid_o", bus.valid_o, 1'b0);
        chk("post-reset progress", bus.progress_done_o, 1'b0);

        // Back-to-back frame.
        run_frame("f1", 1'b0, 1'b1, wins, dones);
        chk("f1 windows", 32'(wins), 32'd9);
        chk("f1 dones", 32'(dones), 32'd1);

        // Gapped frame.
        run_frame("f2gap", 1'b1, 1'b1, wins, dones);
        chk("f2gap windows", 32'(wins), 32'd9);
        chk("f2gap dones", 32'(dones), 32'd1);

        // Two frames with frame-2 beat 0 presented in the DONE cycle.
        run_frame("f3a", 1'b0, 1'b0, wins, dones);
        chk("f3a dones", 32'(dones), 32'd1);
        run_frame("f3b", 1'b0, 1'b1, wins, dones);
        chk("f3b windows", 32'(wins), 32'd9);
        chk("f3b dones", 32'(dones), 32'd1);

        // Reset after beat 7 aborts the frame.
        for (int n = 0; n < 7; n++) begin
            step(tbl[n].vld, tbl[n].col);
            check_vec(n, $sformatf("abort beat%0d", n));
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0);
            chk($sformatf("abort rst%0d window_o", i), bus.window_o, '0);
            chk($sformatf("abort rst%0d done_o", i), bus.done_o, 1'b0);
            chk($sformatf("abort rst%0d progress", i), bus.progress_done_o, 1'b0);
        end
        rst = 1'b1;
        step(1'b0, '0);
        chk("abort idle done_o", bus.done_o, 1'b0);
        run_frame("f4", 1'b0, 1'b1, wins, dones);
        chk("f4 windows", 32'(wins), 32'd9);
        chk("f4 dones", 32'(dones), 32'd1);

        // K=5 instance on an 8x6 image.
        wins5 = 0;
        for (int n = 0; n < COLS5 * (ROWS5 - K5 + 1); n++) begin
            bus5.valid_i = 1'b1;
            bus5.col_i   = mkcol5(n);
            @(posedge clk);
            #1;
            chk($sformatf("k5 beat%0d valid_o", n), bus5.valid_o, (n % COLS5) >= K5 - 1);
            chk($sformatf("k5 beat%0d done_o", n), bus5.done_o, n == COLS5 * 2 - 1);
            if (bus5.valid_o) begin
                wins5++;
                if (n == 4 || n == 15)
                    chk($sformatf("k5 beat%0d window_o", n), bus5.window_o, mkwin5(n));
`ifdef WINDOW_BUF_COORD_EN
                if (n == 4) begin
                    chk("k5 first x_o", bus5.x_o, 2);
                    chk("k5 first y_o", bus5.y_o, 2);
                end
                if (n == 15) begin
                    chk("k5 last x_o", bus5.x_o, 5);
                    chk("k5 last y_o", bus5.y_o, 3);
                end
`endif
            end
        end
        bus5.valid_i = 1'b0;
        bus5.col_i   = '0;
        @(posedge clk);
        #1;
        chk("k5 tail done_o", bus5.done_o, 1'b0);
        chk("k5 tail progress", bus5.progress_done_o, 1'b1);
        chk("k5 windows", 32'(wins5), 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
